// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for regfile_wb_arbiter: pipeline and lsu write requests,
// decode busy lookups and the single register-file write port.
interface regfile_wb_arbiter_if;
    logic        pipe_wren;
    logic [4:0]  pipe_wt_addr;
    logic [31:0] pipe_wt_val;
    logic        pipe_stall;

    logic        lsu_valid;
    logic [4:0]  lsu_wt_addr;
    logic [31:0] lsu_wt_val;
    logic        lsu_ready;

    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_busy;
    logic        rt_busy;

    logic        wb_regfile_wren;
    logic [4:0]  wb_regfile_wt_addr;
    logic [31:0] wb_regfile_wt_val;
    logic [1:0]  fifo_count;

    modport master (
        output pipe_wren, pipe_wt_addr, pipe_wt_val,
        output lsu_valid, lsu_wt_addr, lsu_wt_val,
        output issue_valid, issue_addr, rs_addr, rt_addr,
        input  pipe_stall, lsu_ready, rs_busy, rt_busy,
        input  wb_regfile_wren, wb_regfile_wt_addr, wb_regfile_wt_val,
        input  fifo_count
    );

    modport slave (
        input  pipe_wren, pipe_wt_addr, pipe_wt_val,
        input  lsu_valid, lsu_wt_addr, lsu_wt_val,
        input  issue_valid, issue_addr, rs_addr, rt_addr,
        output pipe_stall, lsu_ready, rs_busy, rt_busy,
        output wb_regfile_wren, wb_regfile_wt_addr, wb_regfile_wt_val,
        output fifo_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writes vs. a 2-entry lsu FIFO
// with starvation forcing. Busy scoreboard only when WB_SCOREBOARD_EN is defined.
module regfile_wb_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input logic                 clk,
    input logic                 reset,
    regfile_wb_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    logic [1:0]    count_q, count_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [4:0]    fa_q [2];
    logic [4:0]    fa_d [2];
    logic [31:0]   fv_q [2];
    logic [31:0]   fv_d [2];
    logic [CW-1:0] starve_q, starve_d;
    logic          wb_wren_q, wb_wren_d;
    logic [4:0]    wb_addr_q, wb_addr_d;
    logic [31:0]   wb_val_q, wb_val_d;

    logic        pipe_req;
    logic        fifo_ne;
    logic        force_pop;
    logic        pipe_win;
    logic        pop;
    logic        push;
    logic        ready;
    logic [4:0]  head_addr;
    logic [31:0] head_val;

    assign pipe_req  = bus.pipe_wren && (bus.pipe_wt_addr != 5'd0);
    assign fifo_ne   = (count_q != 2'd0);
    assign force_pop = fifo_ne && (starve_q == SMAX);
    assign pipe_win  = pipe_req && !force_pop;
    assign pop       = fifo_ne && !pipe_win;
    assign ready     = (count_q != 2'd2);
    assign push      = bus.lsu_valid && ready;
    assign head_addr = fa_q[rd_ptr_q];
    assign head_val  = fv_q[rd_ptr_q];

    assign bus.pipe_stall         = force_pop;
    assign bus.lsu_ready          = ready;
    assign bus.fifo_count         = count_q;
    assign bus.wb_regfile_wren    = wb_wren_q;
    assign bus.wb_regfile_wt_addr = wb_addr_q;
    assign bus.wb_regfile_wt_val  = wb_val_q;

    always_comb begin
        fa_d     = fa_q;
        fv_d     = fv_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fa_d[wr_ptr_q] = bus.lsu_wt_addr;
            fv_d[wr_ptr_q] = bus.lsu_wt_val;
            wr_ptr_d       = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Counter only climbs while the head is waiting behind a pipeline write.
    always_comb begin
        starve_d = starve_q;
        if (!fifo_ne || pop) begin
            starve_d = '0;
        end else if (pipe_win && (starve_q != SMAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        wb_wren_d = 1'b0;
        wb_addr_d = 5'd0;
        wb_val_d  = 32'd0;
        if (pipe_win) begin
            wb_wren_d = 1'b1;
            wb_addr_d = bus.pipe_wt_addr;
            wb_val_d  = bus.pipe_wt_val;
        end else if (pop) begin
            wb_wren_d = (head_addr != 5'd0);
            wb_addr_d = head_addr;
            wb_val_d  = head_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= 2'd0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            fa_q[0]   <= 5'd0;
            fa_q[1]   <= 5'd0;
            fv_q[0]   <= 32'd0;
            fv_q[1]   <= 32'd0;
            starve_q  <= '0;
            wb_wren_q <= 1'b0;
            wb_addr_q <= 5'd0;
            wb_val_q  <= 32'd0;
        end else begin
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            fa_q      <= fa_d;
            fv_q      <= fv_d;
            starve_q  <= starve_d;
            wb_wren_q <= wb_wren_d;
            wb_addr_q <= wb_addr_d;
            wb_val_q  <= wb_val_d;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    // Set is applied after clear so a same-cycle reissue keeps the bit.
    always_comb begin
        busy_d = busy_q;
        if (pop && (head_addr != 5'd0)) begin
            busy_d[head_addr] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_addr != 5'd0)) begin
            busy_d[bus.issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bus.rs_busy = busy_q[bus.rs_addr] && (bus.rs_addr != 5'd0);
    assign bus.rt_busy = busy_q[bus.rt_addr] && (bus.rt_addr != 5'd0);
`else
    logic unused_sb;
    assign unused_sb = ^{bus.issue_valid, bus.issue_addr,
                         bus.rs_addr, bus.rt_addr};
    assign bus.rs_busy = 1'b0;
    assign bus.rt_busy = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed stimulus queues
// expected writes, a negedge monitor pops and compares them.
module tb_regfile_wb_arbiter;
`ifdef WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] v;
    } wb_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    wb_t  exp_q [$];

    regfile_wb_arbiter_if bus();

    regfile_wb_arbiter #(.STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic expect_wb(input logic [4:0] a, input logic [31:0] v);
        wb_t e;
        e.a = a;
        e.v = v;
        exp_q.push_back(e);
    endtask

    task automatic pipe(input logic [4:0] a, input logic [31:0] v);
        bus.pipe_wren    = 1'b1;
        bus.pipe_wt_addr = a;
        bus.pipe_wt_val  = v;
    endtask

    task automatic lsu(input logic [4:0] a, input logic [31:0] v);
        bus.lsu_valid   = 1'b1;
        bus.lsu_wt_addr = a;
        bus.lsu_wt_val  = v;
    endtask

    always @(negedge clk) begin
        if (!reset && bus.wb_regfile_wren) begin
            wb_t e;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected got=%h/%h exp=none",
                         bus.wb_regfile_wt_addr, bus.wb_regfile_wt_val);
            end else begin
                e = exp_q.pop_front();
                chk("wb_addr", 32'(bus.wb_regfile_wt_addr), 32'(e.a));
                chk("wb_val", bus.wb_regfile_wt_val, e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.pipe_wren    = 1'b0;
        bus.pipe_wt_addr = 5'd0;
        bus.pipe_wt_val  = 32'd0;
        bus.lsu_valid    = 1'b0;
        bus.lsu_wt_addr  = 5'd0;
        bus.lsu_wt_val   = 32'd0;
        bus.issue_valid  = 1'b0;
        bus.issue_addr   = 5'd0;
        bus.rs_addr      = 5'd0;
        bus.rt_addr      = 5'd0;

        @(negedge clk);
        chk("rst_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_ready", 32'(bus.lsu_ready), 32'd1);
        chk("rst_wren", 32'(bus.wb_regfile_wren), 32'd0);
        chk("rst_addr", 32'(bus.wb_regfile_wt_addr), 32'd0);
        chk("rst_val", bus.wb_regfile_wt_val, 32'd0);
        chk("rst_stall", 32'(bus.pipe_stall), 32'd0);
        reset = 1'b0;

        // Single pipeline write into an idle arbiter
        @(negedge clk);
        pipe(5'd5, 32'h1234);
        expect_wb(5'd5, 32'h1234);
        chk("t1_stall", 32'(bus.pipe_stall), 32'd0);
        @(negedge clk);
        bus.pipe_wren = 1'b0;
        chk("t1_wren", 32'(bus.wb_regfile_wren), 32'd1);
        @(negedge clk);
        chk("t1_idle", 32'(bus.wb_regfile_wren), 32'd0);

        // Fill FIFO behind pipe writes, then drain; full FIFO refuses a push
        @(negedge clk);
        pipe(5'd10, 32'hA0);
        lsu(5'd3, 32'h33);
        expect_wb(5'd10, 32'hA0);
        @(negedge clk);
        chk("t2_cnt1", 32'(bus.fifo_count), 32'd1);
        chk("t2_rdy1", 32'(bus.lsu_ready), 32'd1);
        pipe(5'd11, 32'hA1);
        lsu(5'd4, 32'h44);
        expect_wb(5'd11, 32'hA1);
        @(negedge clk);
        chk("t2_cnt2", 32'(bus.fifo_count), 32'd2);
        chk("t2_rdy0", 32'(bus.lsu_ready), 32'd0);
        chk("t2_stall", 32'(bus.pipe_stall), 32'd0);
        bus.pipe_wren = 1'b0;
        lsu(5'd5, 32'h55);
        expect_wb(5'd3, 32'h33);
        expect_wb(5'd4, 32'h44);
        @(negedge clk);
        bus.lsu_valid = 1'b0;
        chk("t2_full_nopush", 32'(bus.fifo_count), 32'd1);
        chk("t2_out3", 32'(bus.wb_regfile_wt_addr), 32'd3);
        @(negedge clk);
        chk("t2_cnt0", 32'(bus.fifo_count), 32'd0);
        chk("t2_out4", 32'(bus.wb_regfile_wt_addr), 32'd4);

        // Starvation: head 7 waits behind four pipe writes, then is forced
        @(negedge clk);
        pipe(5'd20, 32'h100);
        lsu(5'd7, 32'h77);
        chk("t3_stall0", 32'(bus.pipe_stall), 32'd0);
        expect_wb(5'd20, 32'h100);
        @(negedge clk);
        bus.lsu_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            pipe(5'(20 + i), 32'h100 + 32'(i));
            chk("t3_nostall", 32'(bus.pipe_stall), 32'd0);
            expect_wb(5'(20 + i), 32'h100 + 32'(i));
            @(negedge clk);
        end
        pipe(5'd25, 32'h105);
        chk("t3_cnt_wait", 32'(bus.fifo_count), 32'd1);
        chk("t3_stall1", 32'(bus.pipe_stall), 32'd1);
        expect_wb(5'd7, 32'h77);
        @(negedge clk);
        chk("t3_stall_rel", 32'(bus.pipe_stall), 32'd0);
        chk("t3_forced7", 32'(bus.wb_regfile_wt_addr), 32'd7);
        chk("t3_cnt0", 32'(bus.fifo_count), 32'd0);
        expect_wb(5'd25, 32'h105);
        @(negedge clk);
        bus.pipe_wren = 1'b0;
        chk("t3_held25", 32'(bus.wb_regfile_wt_addr), 32'd25);

        // Busy scoreboard with same-cycle reissue
        @(negedge clk);
        bus.rs_addr     = 5'd9;
        bus.rt_addr     = 5'd9;
        bus.issue_valid = 1'b1;
        bus.issue_addr  = 5'd9;
        chk("t4_rs_pre", 32'(bus.rs_busy), 32'd0);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        chk("t4_rs_set", 32'(bus.rs_busy), 32'(SB));
        chk("t4_rt_set", 32'(bus.rt_busy), 32'(SB));
        lsu(5'd9, 32'h99);
        @(negedge clk);
        bus.lsu_valid   = 1'b0;
        bus.issue_valid = 1'b1;
        chk("t4_rs_wait", 32'(bus.rs_busy), 32'(SB));
        expect_wb(5'd9, 32'h99);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        chk("t4_rs_reissue", 32'(bus.rs_busy), 32'(SB));
        lsu(5'd9, 32'h9A);
        @(negedge clk);
        bus.lsu_valid = 1'b0;
        chk("t4_rs_wait2", 32'(bus.rs_busy), 32'(SB));
        expect_wb(5'd9, 32'h9A);
        @(negedge clk);
        chk("t4_rs_clr", 32'(bus.rs_busy), 32'd0);
        chk("t4_rt_clr", 32'(bus.rt_busy), 32'd0);
        chk("t4_out9", 32'(bus.wb_regfile_wt_addr), 32'd9);

        // Address-0 writes from both sources are suppressed
        @(negedge clk);
        lsu(5'd0, 32'hFFFF);
        @(negedge clk);
        bus.lsu_valid = 1'b0;
        chk("t5_cnt1", 32'(bus.fifo_count), 32'd1);
        @(negedge clk);
        chk("t5_cnt0", 32'(bus.fifo_count), 32'd0);
        chk("t5_wren0", 32'(bus.wb_regfile_wren), 32'd0);
        pipe(5'd0, 32'hDEAD);
        chk("t5_stall0", 32'(bus.pipe_stall), 32'd0);
        @(negedge clk);
        bus.pipe_wren = 1'b0;
        chk("t5_pipe0", 32'(bus.wb_regfile_wren), 32'd0);

        // Mid-operation reset with a full FIFO and a busy register
        @(negedge clk);
        bus.issue_valid = 1'b1;
        bus.issue_addr  = 5'd9;
        pipe(5'd12, 32'hC0);
        lsu(5'd1, 32'h11);
        expect_wb(5'd12, 32'hC0);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        pipe(5'd13, 32'hC1);
        lsu(5'd2, 32'h22);
        expect_wb(5'd13, 32'hC1);
        @(negedge clk);
        bus.pipe_wren = 1'b0;
        bus.lsu_valid = 1'b0;
        chk("t6_cnt2", 32'(bus.fifo_count), 32'd2);
        chk("t6_busy", 32'(bus.rs_busy), 32'(SB));
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_cnt", 32'(bus.fifo_count), 32'd0);
        chk("t6_rst_ready", 32'(bus.lsu_ready), 32'd1);
        chk("t6_rst_busy", 32'(bus.rs_busy), 32'd0);
        chk("t6_rst_wren", 32'(bus.wb_regfile_wren), 32'd0);
        chk("t6_rst_stall", 32'(bus.pipe_stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_post_cnt", 32'(bus.fifo_count), 32'd0);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive cycles the FIFO head may lose arbitration before it is forced through.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports pipe_wren / pipe_wt_addr / pipe_wt_val  input  1/5/32  in-order pipeline write request.
REQ-005 SHALL have port pipe_stall  output  1  pipeline request not accepted this cycle; upstream holds it unchanged.
REQ-006 SHALL have ports lsu_valid / lsu_wt_addr / lsu_wt_val  input  1/5/32  long-latency (load-miss/divide) result.
REQ-007 SHALL have port lsu_ready  output  1  FIFO can accept an lsu result this cycle.
REQ-008 SHALL have ports issue_valid / issue_addr  input  1/5  a long-latency op targeting issue_addr is issued.
REQ-009 SHALL have ports rs_addr / rt_addr  input  5 each  decode source registers.
REQ-010 SHALL have ports rs_busy / rt_busy  output  1 each  source has an outstanding long-latency write.
REQ-011 SHALL have ports wb_regfile_wren / wb_regfile_wt_addr / wb_regfile_wt_val  output  1/5/32  single register-file write port.
REQ-012 SHALL have port fifo_count  output  2  current lsu FIFO occupancy, 0..2.

Function
REQ-013 SHALL hold lsu results in a 2-entry FIFO; lsu handshake completes when lsu_valid && lsu_ready.
REQ-014 SHALL drive lsu_ready = (fifo_count != 2) from registered count only; no push into a full FIFO even if a pop occurs that cycle.
REQ-015 SHALL treat a pipe request as present only when pipe_wren && pipe_wt_addr != 0.
REQ-016 SHALL each cycle select: pipe request if present and not stalled; else FIFO head if non-empty (pop); else idle.
REQ-017 SHALL keep a starvation counter: increments when FIFO non-empty and pipe wins; clears on any pop or when FIFO empty; saturates at STARVE_MAX.
REQ-018 SHALL assert pipe_stall combinationally when counter == STARVE_MAX and FIFO non-empty; the head then pops that cycle.
REQ-019 SHALL register the selected write: wb_regfile_* valid exactly one cycle after selection; wren=0 on idle cycles.
REQ-020 SHALL pop a FIFO entry with address 0 normally but emit wb_regfile_wren=0 for it.
REQ-021 SHALL keep a 32-bit busy scoreboard: issue_valid with issue_addr != 0 sets bit at the clock edge.
REQ-022 SHALL clear busy[a] at the edge on which a popped FIFO entry with address a is registered to the output.
REQ-023 SHALL let set win over clear when both target the same address in one cycle.
REQ-024 SHALL leave the scoreboard unaffected by pipe writes.
REQ-025 SHALL drive rs_busy = busy[rs_addr] && rs_addr != 0 (likewise rt), combinationally from registered state.
REQ-026 SHALL keep FIFO order strictly first-in-first-out; pointers wrap modulo 2.

Reset
REQ-027 SHALL, while reset is high, asynchronously force: FIFO empty, fifo_count=0, lsu_ready=1, counter=0, scoreboard all 0, wb_regfile_wren=0, wb_regfile_wt_addr=0, wb_regfile_wt_val=0, pipe_stall=0.
REQ-028 SHALL discard any FIFO contents and pending output on reset mid-operation; first valid output no earlier than 1 cycle after selection following reset release.

Configuration
REQ-029 SHALL implement the scoreboard (REQ-021..025) only when macro WB_SCOREBOARD_EN is defined.
REQ-030 SHALL, without WB_SCOREBOARD_EN, tie rs_busy/rt_busy to 0, ignore issue_valid/issue_addr, and keep all other behaviour identical.

Verification
REQ-031 SHALL cover: pipe_wren=1,addr=5,val=0x1234 idle FIFO -> next cycle wren=1,addr=5,val=0x1234, pipe_stall=0.
REQ-032 SHALL cover: two lsu pushes (addr 3,4) with pipe idle -> outputs addr 3 then 4 on consecutive cycles; fifo_count 2->1->0; lsu_ready=0 while count=2.
REQ-033 SHALL cover: FIFO head addr 7 plus continuous pipe writes, STARVE_MAX=4 -> 4 pipe writes emitted, then pipe_stall=1 for one cycle and addr 7 emitted; held pipe request emitted next.
REQ-034 SHALL cover: issue_valid addr 9 then rs_addr=9 -> rs_busy=1 until lsu result addr 9 reaches output, then 0; same-cycle reissue of 9 keeps rs_busy=1.
REQ-035 SHALL cover: lsu entry addr 0 val 0xFFFF -> popped, wb_regfile_wren=0; pipe_wren addr 0 -> no output, no stall.
REQ-036 SHALL cover: reset asserted with count=2 and busy[9]=1 -> immediately count=0, busy clear, wren=0, lsu_ready=1.
